sme_rng_source: RTL and testbench
=================================

// Module: sme_rng_source
// PURPOSE
//  Masking-randomness producer for the SME. Supplies the D words of fresh randomness
//  (rng[D-1:0]) consumed by DOM gadgets, one refresh per accepted request.
//  Internals: D independent xorshift32 lanes; an externally supplied seed; warm-up
//  stepping; a reseed request after a configurable number of draws.
// PARAMETERS
//  D                2     number of shares = number of rng lanes
//  WARMUP           16    lane steps after initial seeding before output is valid (0 = none)
//  RESEED_INTERVAL  1024  draws after which reseed_req asserts (>=1)
// PORTS
//  g_clk       in   1          global clock, all state on rising edge
//  g_reset     in   1          asynchronous, active-high reset
//  g_clk_req   out  1          clock request: high in LOAD/WARM, or when en=1, or when seed_valid=1
//  seed_valid  in   1          seed word offered
//  seed_ready  out  1          seed word accepted when seed_valid & seed_ready
//  seed_data   in   XLEN       seed word for lane seed_idx
//  en          in   1          draw: consumer has used the current rng; advance all lanes
//  rng         out  XLEN x D   current randomness, rng[d] = lane d state
//  rng_valid   out  1          rng holds seeded, warmed-up randomness
//  reseed_req  out  1          draw budget exhausted; new seed wanted
// BEHAVIOUR
//  Reset (async): state=IDLE, lanes=0, seed_idx=0, draw_cnt=0, warm_cnt=0.
//   Outputs: rng_valid=0, reseed_req=0, seed_ready=1, g_clk_req=0.
//  step(x): x^=x<<13; x^=x>>17; x^=x<<5 (32-bit).
//   Zero guard: any lane result of 0 is replaced by SME_RNG_CONST[d].
//  FSM
//   IDLE: on seed handshake -> lane[0]=seed_data, seed_idx=1, go LOAD
//         (if D=1: go straight to WARM/RUN as for the last word).
//   LOAD: each handshake writes lane[seed_idx], seed_idx++.
//         On the handshake for word D-1: seed_idx=0; go WARM with warm_cnt=WARMUP-1,
//         or go RUN directly if WARMUP=0.
//   WARM: seed_ready=0; all lanes step every cycle; warm_cnt--.
//         When warm_cnt==0 on an edge -> RUN. Total WARMUP steps.
//   RUN:  rng_valid=1.
//         en=1: all lanes step on the edge; draw_cnt++ (saturating at RESEED_INTERVAL).
//         draw_cnt==RESEED_INTERVAL -> reseed_req=1 (registered, visible the cycle after the
//         edge that reaches it). Output stays valid and usable while reseed_req=1.
//         Seed handshake in RUN mixes: lane[seed_idx]^=seed_data, seed_idx++.
//         After word D-1: seed_idx=0, draw_cnt=0, reseed_req=0 on that edge.
//  Latency
//   - en at edge k -> new rng visible after edge k.
//   - Last seed word at edge k -> rng_valid=1 after edge k+WARMUP.
//  Boundary conditions
//   - en while rng_valid=0 is ignored; no step, no count.
//   - en and seed mix to the same lane on the same edge: lane=step(lane)^seed_data,
//     then zero guard.
//   - Zero seed or zero mix result: lane=SME_RNG_CONST[d].
//   - Partial reseed: draw_cnt and reseed_req unchanged until word D-1 arrives.
//   - Async reset mid-LOAD/WARM/RUN: all state and outputs return to reset values
//     immediately; partial seeds are discarded.
//   - draw_cnt never wraps.
// STRUCTURE
//  sme_pkg gains:
//   - SME_RNG_CONST[0..7], distinct non-zero 32-bit lane constants.
//   - typedef enum logic [1:0] {SME_RNG_IDLE, SME_RNG_LOAD, SME_RNG_WARM, SME_RNG_RUN}
//     sme_rng_state_t.
//   - XLEN is taken from sme_pkg.
//  Sub-module sme_rng_lane (one per d)
//   - Inputs: step, load, mix, seed, and const via parameter LANE.
//   - Holds one 32-bit state with the step/mix/zero-guard logic.
//  Top level owns the FSM, seed_idx, warm_cnt and draw_cnt.
// TESTING
//  1. D=3, WARMUP=0; seed 1,2,3 -> rng_valid=1 after 3rd handshake; rng={3,2,1}.
//     Then en=1 for 1 cycle -> rng[0]=0x00042021.
//  2. D=3, WARMUP=2; seed 1,2,3 -> rng_valid low for 2 cycles with seed_ready=0;
//     then rng[0]=step(0x00042021).
//  3. Seed word 0 for lane 1 -> rng[1]=SME_RNG_CONST[1]; other lanes hold their seeds.
//  4. RESEED_INTERVAL=4: 4 en pulses -> reseed_req=1 next cycle, rng_valid stays 1.
//     Further en still steps lanes. 3 mix words -> reseed_req=0.
//     Lanes equal step^n(x)^seed.
//  5. Same-edge en + mix on lane 0 (lane=1, seed=0x10) -> lane0=0x00042031.
//     en with rng_valid=0 -> no change.
//  6. Assert g_reset mid-WARM and mid-RUN -> outputs reach reset values without a clock
//     edge. Then a full reseed is required before rng_valid returns.

Source files
------------

// File: rtl/sme_pkg.sv
// Shared SME definitions: data width, rng lane constants, FSM state encoding
// and the xorshift32 step used by every randomness lane.
package sme_pkg;

  localparam int XLEN = 32;

  // Lane d substitutes SME_RNG_CONST[d] whenever its state would become zero.
  localparam logic [7:0][31:0] SME_RNG_CONST = {
    32'h1F83D9AB, 32'h9B05688C, 32'h510E527F, 32'hA54FF53A,
    32'h3C6EF372, 32'hBB67AE85, 32'h7F4A7C15, 32'h9E3779B9
  };

  typedef enum logic [1:0] {
    SME_RNG_IDLE,
    SME_RNG_LOAD,
    SME_RNG_WARM,
    SME_RNG_RUN
  } sme_rng_state_t;

  function automatic logic [31:0] sme_rng_step(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

endpackage

// File: rtl/sme_rng_lane.sv
// One xorshift32 randomness lane: load, step and seed-mix with zero guard.
// A step and a mix on the same edge apply the step first, then xor the seed.
module sme_rng_lane
  import sme_pkg::*;
#(
  parameter int LANE = 0
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            step,
  input  logic            load,
  input  logic            mix,
  input  logic [XLEN-1:0] seed,
  output logic [XLEN-1:0] state
);

  logic [XLEN-1:0] state_reg;
  logic [XLEN-1:0] stepped;
  logic [XLEN-1:0] state_next;

  always_comb begin
    stepped    = step ? sme_rng_step(state_reg) : state_reg;
    state_next = load ? seed : (mix ? (stepped ^ seed) : stepped);
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_reg <= '0;
    end else if (load || step || mix) begin
      state_reg <= (state_next == '0) ? SME_RNG_CONST[LANE] : state_next;
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/sme_rng_source.sv
// Masking-randomness source: D xorshift lanes seeded word by word, warmed up,
// then advanced per draw, requesting a reseed once the draw budget is spent.
module sme_rng_source
  import sme_pkg::*;
#(
  parameter int D               = 2,
  parameter int WARMUP          = 16,
  parameter int RESEED_INTERVAL = 1024
) (
  input  logic                   g_clk,
  input  logic                   g_reset,
  output logic                   g_clk_req,
  input  logic                   seed_valid,
  output logic                   seed_ready,
  input  logic [XLEN-1:0]        seed_data,
  input  logic                   en,
  output logic [D-1:0][XLEN-1:0] rng,
  output logic                   rng_valid,
  output logic                   reseed_req
);

  localparam int IDX_W  = (D > 1) ? $clog2(D) : 1;
  localparam int WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int DRAW_W = $clog2(RESEED_INTERVAL + 1);

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(D - 1);
  localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [DRAW_W-1:0] DRAW_MAX  = DRAW_W'(RESEED_INTERVAL);

  sme_rng_state_t    state_reg;
  logic [IDX_W-1:0]  seed_idx_reg;
  logic [WARM_W-1:0] warm_cnt_reg;
  logic [DRAW_W-1:0] draw_cnt_reg;
  logic              rng_valid_reg;
  logic              reseed_req_reg;
  logic              seed_ready_reg;

  logic seed_hs;
  logic last_word;
  logic loading;
  logic mixing;
  logic step_all;

  assign seed_hs   = seed_valid && seed_ready_reg;
  assign last_word = (seed_idx_reg == LAST_IDX);
  assign loading   = seed_hs && ((state_reg == SME_RNG_IDLE) || (state_reg == SME_RNG_LOAD));
  assign mixing    = seed_hs && (state_reg == SME_RNG_RUN);
  // Draws are ignored until the lanes hold warmed-up randomness.
  assign step_all  = (state_reg == SME_RNG_WARM) || ((state_reg == SME_RNG_RUN) && en);

  for (genvar gi = 0; gi < D; gi++) begin : g_lane
    sme_rng_lane #(
      .LANE(gi)
    ) u_lane (
      .g_clk  (g_clk),
      .g_reset(g_reset),
      .step   (step_all),
      .load   (loading && (seed_idx_reg == IDX_W'(gi))),
      .mix    (mixing && (seed_idx_reg == IDX_W'(gi))),
      .seed   (seed_data),
      .state  (rng[gi])
    );
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_reg      <= SME_RNG_IDLE;
      seed_idx_reg   <= '0;
      warm_cnt_reg   <= '0;
      draw_cnt_reg   <= '0;
      rng_valid_reg  <= 1'b0;
      reseed_req_reg <= 1'b0;
      seed_ready_reg <= 1'b1;
    end else begin
      case (state_reg)
        SME_RNG_IDLE, SME_RNG_LOAD: begin
          if (seed_hs) begin
            if (last_word) begin
              seed_idx_reg <= '0;
              if (WARMUP == 0) begin
                state_reg     <= SME_RNG_RUN;
                rng_valid_reg <= 1'b1;
              end else begin
                state_reg      <= SME_RNG_WARM;
                warm_cnt_reg   <= WARM_INIT;
                seed_ready_reg <= 1'b0;
              end
            end else begin
              seed_idx_reg <= seed_idx_reg + 1'b1;
              state_reg    <= SME_RNG_LOAD;
            end
          end
        end
        SME_RNG_WARM: begin
          if (warm_cnt_reg == '0) begin
            state_reg      <= SME_RNG_RUN;
            rng_valid_reg  <= 1'b1;
            seed_ready_reg <= 1'b1;
          end else begin
            warm_cnt_reg <= warm_cnt_reg - 1'b1;
          end
        end
        SME_RNG_RUN: begin
          if (en) begin
            if (draw_cnt_reg != DRAW_MAX) begin
              draw_cnt_reg <= draw_cnt_reg + 1'b1;
            end
            if (draw_cnt_reg >= (DRAW_MAX - 1'b1)) begin
              reseed_req_reg <= 1'b1;
            end
          end
          // Completing a reseed clears the budget even if a draw lands on the same edge.
          if (seed_hs) begin
            if (last_word) begin
              seed_idx_reg   <= '0;
              draw_cnt_reg   <= '0;
              reseed_req_reg <= 1'b0;
            end else begin
              seed_idx_reg <= seed_idx_reg + 1'b1;
            end
          end
        end
        default: state_reg <= SME_RNG_IDLE;
      endcase
    end
  end

  assign seed_ready = seed_ready_reg;
  assign rng_valid  = rng_valid_reg;
  assign reseed_req = reseed_req_reg;
  assign g_clk_req  = (state_reg == SME_RNG_LOAD) || (state_reg == SME_RNG_WARM) || en || seed_valid;

endmodule

// File: tb/tb_sme_rng_source.sv
// Directed bench for sme_rng_source: instance a (no warm-up, budget 4 draws)
// and instance b (two warm-up steps) driven by one linear sequence.
module tb_sme_rng_source;

  localparam logic [31:0] C1 = 32'h7F4A7C15;

  logic g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  logic             a_rst, a_clk_req, a_seed_valid, a_seed_ready, a_en, a_rng_valid, a_reseed_req;
  logic [31:0]      a_seed_data;
  logic [2:0][31:0] a_rng;
  logic             b_rst, b_clk_req, b_seed_valid, b_seed_ready, b_en, b_rng_valid, b_reseed_req;
  logic [31:0]      b_seed_data;
  logic [2:0][31:0] b_rng;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] m [3];

  sme_rng_source #(.D(3), .WARMUP(0), .RESEED_INTERVAL(4)) u_dut_a (
    .g_clk(g_clk), .g_reset(a_rst), .g_clk_req(a_clk_req),
    .seed_valid(a_seed_valid), .seed_ready(a_seed_ready), .seed_data(a_seed_data),
    .en(a_en), .rng(a_rng), .rng_valid(a_rng_valid), .reseed_req(a_reseed_req)
  );

  sme_rng_source #(.D(3), .WARMUP(2), .RESEED_INTERVAL(1024)) u_dut_b (
    .g_clk(g_clk), .g_reset(b_rst), .g_clk_req(b_clk_req),
    .seed_valid(b_seed_valid), .seed_ready(b_seed_ready), .seed_data(b_seed_data),
    .en(b_en), .rng(b_rng), .rng_valid(b_rng_valid), .reseed_req(b_reseed_req)
  );

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic a_seed(input logic [31:0] w);
    a_seed_valid = 1'b1;
    a_seed_data  = w;
    tick();
    a_seed_valid = 1'b0;
  endtask

  task automatic b_seed(input logic [31:0] w);
    b_seed_valid = 1'b1;
    b_seed_data  = w;
    tick();
    b_seed_valid = 1'b0;
  endtask

  initial begin
    a_rst = 1'b1; a_seed_valid = 1'b0; a_seed_data = '0; a_en = 1'b0;
    b_rst = 1'b1; b_seed_valid = 1'b0; b_seed_data = '0; b_en = 1'b0;
    repeat (2) tick();
    a_rst = 1'b0;
    b_rst = 1'b0;
    tick();

    // Reset state
    chk("a_rst_valid", a_rng_valid, 0);
    chk("a_rst_reseed", a_reseed_req, 0);
    chk("a_rst_ready", a_seed_ready, 1);
    chk("a_rst_clkreq", a_clk_req, 0);
    chk("a_rst_rng0", a_rng[0], 0);
    chk("b_rst_ready", b_seed_ready, 1);

    // Draw before seeding is ignored
    a_en = 1'b1;
    #1 chk("a_clkreq_en", a_clk_req, 1);
    tick();
    a_en = 1'b0;
    chk("a_en_idle_valid", a_rng_valid, 0);
    chk("a_en_idle_rng0", a_rng[0], 0);

    // Seeding with no warm-up
    a_seed(32'd1);
    chk("a_load_clkreq", a_clk_req, 1);
    chk("a_load_valid", a_rng_valid, 0);
    a_seed(32'd2);
    a_seed(32'd3);
    chk("a_seeded_valid", a_rng_valid, 1);
    chk("a_seeded_rng0", a_rng[0], 32'd1);
    chk("a_seeded_rng1", a_rng[1], 32'd2);
    chk("a_seeded_rng2", a_rng[2], 32'd3);

    a_en = 1'b1;
    tick();
    a_en = 1'b0;
    chk("a_draw1_rng0", a_rng[0], 32'h00042021);
    chk("a_draw1_rng1", a_rng[1], 32'h00084042);
    chk("a_draw1_rng2", a_rng[2], 32'h000C6063);
    chk("a_draw1_reseed", a_reseed_req, 0);
    m[0] = 32'h00042021; m[1] = 32'h00084042; m[2] = 32'h000C6063;

    // Budget of 4 draws, then one more draw while reseed_req is high
    for (int k = 2; k <= 5; k++) begin
      a_en = 1'b1;
      tick();
      a_en = 1'b0;
      for (int i = 0; i < 3; i++) m[i] = xs(m[i]);
      chk($sformatf("a_draw%0d_reseed", k), a_reseed_req, (k >= 4) ? 1 : 0);
      chk($sformatf("a_draw%0d_rng0", k), a_rng[0], m[0]);
      chk($sformatf("a_draw%0d_valid", k), a_rng_valid, 1);
    end
    chk("a_draw5_rng2", a_rng[2], m[2]);

    // Reseed by mixing; partial reseed keeps the request
    a_seed(32'h11111111);
    m[0] = m[0] ^ 32'h11111111;
    chk("a_mix0_rng0", a_rng[0], m[0]);
    chk("a_mix0_reseed", a_reseed_req, 1);
    a_seed(32'h22222222);
    m[1] = m[1] ^ 32'h22222222;
    chk("a_mix1_rng1", a_rng[1], m[1]);
    chk("a_mix1_reseed", a_reseed_req, 1);
    a_seed(32'h33333333);
    m[2] = m[2] ^ 32'h33333333;
    chk("a_mix2_rng2", a_rng[2], m[2]);
    chk("a_mix2_reseed", a_reseed_req, 0);
    chk("a_mix2_valid", a_rng_valid, 1);

    // Budget restarted from zero
    for (int k = 1; k <= 4; k++) begin
      a_en = 1'b1;
      tick();
      a_en = 1'b0;
      for (int i = 0; i < 3; i++) m[i] = xs(m[i]);
      chk($sformatf("a_rebudget%0d_reseed", k), a_reseed_req, (k == 4) ? 1 : 0);
    end
    chk("a_rebudget_rng1", a_rng[1], m[1]);

    // Warm-up instance
    b_seed(32'd1);
    b_seed(32'd2);
    b_seed(32'd3);
    chk("b_warm0_ready", b_seed_ready, 0);
    chk("b_warm0_valid", b_rng_valid, 0);
    chk("b_warm0_clkreq", b_clk_req, 1);
    tick();
    chk("b_warm1_valid", b_rng_valid, 0);
    chk("b_warm1_ready", b_seed_ready, 0);
    chk("b_warm1_rng0", b_rng[0], 32'h00042021);
    tick();
    chk("b_run_valid", b_rng_valid, 1);
    chk("b_run_ready", b_seed_ready, 1);
    chk("b_run_rng0", b_rng[0], xs(32'h00042021));
    chk("b_run_rng2", b_rng[2], xs(32'h000C6063));

    // Async reset mid-RUN (a, reseed_req currently high) and mid-WARM (b)
    b_rst = 1'b1;
    #2 b_rst = 1'b0;
    tick();
    b_seed(32'd1);
    b_seed(32'd2);
    b_seed(32'd3);
    #3;
    a_rst = 1'b1;
    b_rst = 1'b1;
    #1;
    chk("a_arst_valid", a_rng_valid, 0);
    chk("a_arst_reseed", a_reseed_req, 0);
    chk("a_arst_rng0", a_rng[0], 0);
    chk("a_arst_ready", a_seed_ready, 1);
    chk("b_arst_valid", b_rng_valid, 0);
    chk("b_arst_ready", b_seed_ready, 1);
    chk("b_arst_clkreq", b_clk_req, 0);
    chk("b_arst_rng0", b_rng[0], 0);
    @(negedge g_clk);
    a_rst = 1'b0;
    b_rst = 1'b0;
    repeat (3) tick();
    chk("b_postrst_valid", b_rng_valid, 0);

    a_en = 1'b1;
    tick();
    a_en = 1'b0;
    chk("a_postrst_en_valid", a_rng_valid, 0);
    chk("a_postrst_en_rng0", a_rng[0], 0);

    // Zero seed word for lane 1
    a_seed(32'd1);
    a_seed(32'd0);
    a_seed(32'd3);
    chk("a_zseed_valid", a_rng_valid, 1);
    chk("a_zseed_rng0", a_rng[0], 32'd1);
    chk("a_zseed_rng1", a_rng[1], C1);
    chk("a_zseed_rng2", a_rng[2], 32'd3);

    // Draw and mix into lane 0 on the same edge
    a_en = 1'b1;
    a_seed_valid = 1'b1;
    a_seed_data = 32'h00000010;
    tick();
    a_en = 1'b0;
    a_seed_valid = 1'b0;
    chk("a_enmix_rng0", a_rng[0], 32'h00042031);
    chk("a_enmix_rng1", a_rng[1], xs(C1));
    chk("a_enmix_rng2", a_rng[2], 32'h000C6063);

    // Mix that cancels lane 1 to zero
    a_seed(xs(C1));
    chk("a_zmix_rng1", a_rng[1], C1);
    chk("a_zmix_rng0", a_rng[0], 32'h00042031);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
